// File: rtl/cache_req_pkg.sv
// Shared types for the CPU-side cache request driver: FSM states,
// the queued command record and the datapath widths.
package cache_req_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2,
        WAIT  = 2'd3
    } state_e;

    // 65-bit command as it sits in the FIFO and in the request registers
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/cache_req_fifo.sv
// Command FIFO for the request driver. DEPTH must be a power of two;
// pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate occupancy counter.
module cache_req_fifo
    import cache_req_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  cmd_t push_data_i,
    input  logic pop_i,
    output cmd_t head_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);

    cmd_t          mem_q [DEPTH];
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic          do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rptr_q[AW-1:0]];

    // Pointer advance; push and pop are independent so a simultaneous pair
    // leaves the occupancy unchanged.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    // Pointer registers, cleared by reset so queued commands are discarded
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage array; contents are don't-care while the slot is not occupied
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/cache_cpu_req_driver.sv
// CPU-side request initiator for the cache. Commands are queued, issued one
// at a time on the cache CPU port, held until cpu_ready, and answered with
// one response each, in order.
// Optional feature: CACHE_REQ_TIMEOUT_EN adds a per-request timeout that
// ends a stuck request with rsp_err=1.
module cache_cpu_req_driver
    import cache_req_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int GAP     = 1,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [BYTE_W-1:0] rsp_data,
    output logic              rsp_write,
    output logic              rsp_err,
    output logic              cpu_read,
    output logic              cpu_write,
    output logic [ADDR_W-1:0] cpu_address,
    output logic [DATA_W-1:0] cpu_wdata,
    input  logic [BYTE_W-1:0] cpu_data_in,
    input  logic              cpu_ready,
    output logic              busy
);

    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    state_e            state_q, state_d;
    cmd_t              req_q, req_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic [GW-1:0]     gap_q, gap_d;

    cmd_t              cmd_in;
    cmd_t              fifo_head;
    logic              fifo_pop, fifo_full, fifo_empty;

`ifdef CACHE_REQ_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0]     tmo_q, tmo_d;
`endif

    assign cmd_in = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};

    cache_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (cmd_valid),
        .push_data_i (cmd_in),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Outputs decode straight from registered state, so an async reset drops
    // the request lines at once.
    assign cmd_ready   = !fifo_full;
    assign cpu_read    = (state_q == ISSUE) && !req_q.write;
    assign cpu_write   = (state_q == ISSUE) &&  req_q.write;
    assign cpu_address = req_q.addr;
    assign cpu_wdata   = req_q.wdata;
    assign rsp_valid   = (state_q == RESP);
    assign rsp_data    = data_q;
    assign rsp_write   = req_q.write;
    assign busy        = (state_q != IDLE) || !fifo_empty;
`ifdef CACHE_REQ_TIMEOUT_EN
    assign rsp_err     = err_q;
`else
    assign rsp_err     = 1'b0;
`endif

    // Next-state: pop/issue, wait for the cache, hold the response, then idle
    // for GAP cycles before the next request.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        data_d   = data_q;
        err_d    = err_q;
        gap_d    = gap_q;
        fifo_pop = 1'b0;
`ifdef CACHE_REQ_TIMEOUT_EN
        tmo_d    = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    req_d    = fifo_head;
                    state_d  = ISSUE;
`ifdef CACHE_REQ_TIMEOUT_EN
                    tmo_d    = '0;
`endif
                end
            end
            ISSUE: begin
                // cpu_ready has priority over an expiring timeout
                if (cpu_ready) begin
                    data_d  = req_q.write ? '0 : cpu_data_in;
                    err_d   = 1'b0;
                    state_d = RESP;
                end
`ifdef CACHE_REQ_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    tmo_d   = tmo_q + 1'b1;
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    gap_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (gap_q == GW'(GAP - 1)) state_d = IDLE;
                else                       gap_d   = gap_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and request/capture registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            req_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            err_q   <= err_d;
            gap_q   <= gap_d;
        end
    end

`ifdef CACHE_REQ_TIMEOUT_EN
    // Cycles spent in ISSUE for the current request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tmo_q <= '0;
        else      tmo_q <= tmo_d;
    end
`endif

endmodule

// File: tb/tb_cache_cpu_req_driver.sv
// Self-checking bench for cache_cpu_req_driver: table of single-command
// vectors plus hand-written multi-cycle sequences, against a small cache
// model that raises cpu_ready a programmable number of cycles into a request.
module tb_cache_cpu_req_driver;
    import cache_req_pkg::*;

    localparam int DEPTH = 4;
    localparam int GAP   = 1;
    localparam int TMO   = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_write, rsp_err;
    logic [7:0]  rsp_data;
    logic        cpu_read, cpu_write, cpu_ready = 1'b0, busy;
    logic [31:0] cpu_address, cpu_wdata;
    logic [7:0]  cpu_data_in = '0;

    always #5 clk = ~clk;

    cache_cpu_req_driver #(.DEPTH(DEPTH), .GAP(GAP), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_write(rsp_write), .rsp_err(rsp_err),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
        .cpu_wdata(cpu_wdata), .cpu_data_in(cpu_data_in), .cpu_ready(cpu_ready),
        .busy(busy)
    );

    typedef struct { logic wr; logic [31:0] addr; logic [31:0] wdata; } iss_t;
    typedef struct { logic [7:0] data; logic wr; logic err; } rsp_t;
    typedef struct {
        logic wr; logic [31:0] addr; logic [31:0] wdata; logic [7:0] rdata; int lat;
        logic [7:0] exp_data; logic exp_wr;
    } vec_t;

    iss_t iss_q[$];
    rsp_t rsp_q[$];
    int   len_q[$];
    int   low_q[$];
    int   lat = 0;
    int   hl = 0, lowcnt = 0, both_hi = 0, unstable = 0;
    logic prev_req = 1'b0, req_now;
    int   n_checks = 0, n_err = 0;

    // Cache model and monitor, all sampled on the falling edge
    always @(negedge clk) begin
        req_now = cpu_read || cpu_write;
        if (!rst) begin
            prev_req  = 1'b0;
            hl        = 0;
            lowcnt    = 0;
            cpu_ready = 1'b0;
        end else begin
            if (cpu_read && cpu_write) both_hi++;
            if (req_now) begin
                if (!prev_req) begin
                    iss_q.push_back('{cpu_write, cpu_address, cpu_wdata});
                    low_q.push_back(lowcnt);
                    lowcnt = 0;
                    hl = 1;
                end else begin
                    hl++;
                    if (iss_q.size() > 0 &&
                        (cpu_address !== iss_q[$].addr || cpu_wdata !== iss_q[$].wdata))
                        unstable++;
                end
            end else begin
                if (prev_req) len_q.push_back(hl);
                lowcnt++;
            end
            prev_req  = req_now;
            cpu_ready = req_now && (lat != 0) && (hl >= lat);
            if (rsp_valid && rsp_ready) rsp_q.push_back('{rsp_data, rsp_write, rsp_err});
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clear_q();
        iss_q.delete(); rsp_q.delete(); len_q.delete(); low_q.delete();
    endtask

    // Offer one command; returns 1 cycle after the accepting edge
    task automatic push(input logic wr, input logic [31:0] a, input logic [31:0] d);
        bit ok = 0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1;
        end
        if (!ok) check("push_timeout", 0, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int cnt, input string nm);
        bit ok = 0;
        for (int n = 0; n < 400 && !ok; n++) begin
            @(negedge clk);
            if (rsp_q.size() >= cnt) ok = 1;
        end
        if (!ok) check(nm, rsp_q.size(), cnt);
        @(posedge clk); #1;
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b0, 32'h0000_0104, 32'h0,         8'hA5, 3, 8'hA5, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 8'h11, 1, 8'h00, 1'b1};
        vecs[2] = '{1'b0, 32'h0000_0040, 32'h0,         8'h3C, 2, 8'h3C, 1'b0};
        vecs[3] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         8'hFF, 1, 8'hFF, 1'b0};
        vecs[4] = '{1'b1, 32'h0000_0000, 32'h0,         8'h77, 4, 8'h00, 1'b1};
        vecs[5] = '{1'b0, 32'h8000_0001, 32'h0,         8'h00, 5, 8'h00, 1'b0};

        // Reset state
        #12;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_outputs", {rsp_valid, rsp_data, rsp_write, rsp_err, cpu_read, cpu_write,
                              cpu_address, busy}, 0);
        @(posedge clk); #3 rst = 1'b1;
        @(posedge clk); #1;

        // Table-driven single commands
        foreach (vecs[i]) begin
            clear_q();
            lat = vecs[i].lat;
            cpu_data_in = vecs[i].rdata;
            push(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            wait_rsp(1, $sformatf("v%0d_rsp_timeout", i));
            if (rsp_q.size() > 0) begin
                check($sformatf("v%0d_data", i), rsp_q[0].data, vecs[i].exp_data);
                check($sformatf("v%0d_rsp_write", i), rsp_q[0].wr, vecs[i].exp_wr);
                check($sformatf("v%0d_err", i), rsp_q[0].err, 0);
            end
            if (iss_q.size() > 0) begin
                check($sformatf("v%0d_iss_write", i), iss_q[0].wr, vecs[i].wr);
                check($sformatf("v%0d_iss_addr", i), iss_q[0].addr, vecs[i].addr);
                if (vecs[i].wr) check($sformatf("v%0d_iss_wdata", i), iss_q[0].wdata, vecs[i].wdata);
            end else check($sformatf("v%0d_issued", i), 0, 1);
            if (len_q.size() > 0) check($sformatf("v%0d_req_len", i), len_q[0], vecs[i].lat);
            else check($sformatf("v%0d_req_len_seen", i), 0, 1);
            repeat (4) @(posedge clk); #1;
            check($sformatf("v%0d_idle_busy", i), busy, 0);
        end

        // Write then read back-to-back: ordering and idle gap
        clear_q();
        lat = 1; cpu_data_in = 8'h5C;
        push(1'b1, 32'h40, 32'hDEAD_BEEF);
        push(1'b0, 32'h40, 32'h0);
        wait_rsp(2, "wr_rd_rsp_timeout");
        if (iss_q.size() == 2 && rsp_q.size() == 2 && low_q.size() == 2) begin
            check("wr_rd_first_is_write", iss_q[0].wr, 1);
            check("wr_rd_second_is_read", {iss_q[1].wr, iss_q[1].addr}, {1'b0, 32'h40});
            check("wr_rd_low_gap", low_q[1], 2 + GAP);
            check("wr_rd_rsp0", {rsp_q[0].wr, rsp_q[0].data}, {1'b1, 8'h00});
            check("wr_rd_rsp1", {rsp_q[1].wr, rsp_q[1].data}, {1'b0, 8'h5C});
        end else check("wr_rd_counts", {iss_q.size(), rsp_q.size()}, {32'd2, 32'd2});

        // Five commands into a 4-deep FIFO with the cache stalled
        repeat (3) @(posedge clk); #1;
        clear_q();
        lat = 0; cpu_data_in = 8'h77;
        push(1'b1, 32'h100, 32'h1);
        push(1'b0, 32'h104, 32'h0);
        push(1'b1, 32'h108, 32'h2);
        push(1'b0, 32'h10C, 32'h0);
        push(1'b0, 32'h110, 32'h0);
        begin
            int rdy_seen = 0;
            for (int n = 0; n < 5; n++) begin
                @(negedge clk);
                if (cmd_ready) rdy_seen++;
            end
            check("full_cmd_ready_low", rdy_seen, 0);
            check("full_busy", busy, 1);
        end
        @(posedge clk); #1;
        lat = 1;
        wait_rsp(5, "full_rsp_timeout");
        if (rsp_q.size() == 5 && iss_q.size() == 5) begin
            check("full_rsp_order", {rsp_q[0].wr, rsp_q[1].wr, rsp_q[2].wr, rsp_q[3].wr, rsp_q[4].wr},
                  5'b10100);
            check("full_iss_addr_order", {iss_q[0].addr[7:0], iss_q[1].addr[7:0], iss_q[2].addr[7:0],
                                          iss_q[3].addr[7:0], iss_q[4].addr[7:0]}, 40'h00_04_08_0C_10);
            check("full_rd_data", {rsp_q[1].data, rsp_q[3].data, rsp_q[4].data}, 24'h77_77_77);
        end else check("full_counts", {iss_q.size(), rsp_q.size()}, {32'd5, 32'd5});

        // Response back-pressure for 10 cycles
        repeat (3) @(posedge clk); #1;
        clear_q();
        rsp_ready = 1'b0; lat = 1; cpu_data_in = 8'h3C;
        push(1'b0, 32'h200, 32'h0);
        push(1'b0, 32'h204, 32'h0);
        begin
            bit ok = 0;
            int bad = 0;
            int gapn = 0;
            for (int n = 0; n < 50 && !ok; n++) begin
                @(negedge clk);
                if (rsp_valid) ok = 1;
            end
            check("bp_rsp_valid_seen", ok, 1);
            for (int n = 0; n < 10; n++) begin
                @(negedge clk);
                if (!rsp_valid || rsp_data !== 8'h3C || cpu_read || cpu_write) bad++;
            end
            check("bp_hold_stable", bad, 0);
            @(posedge clk); #1 rsp_ready = 1'b1;
            ok = 0;
            for (int n = 1; n < 20 && !ok; n++) begin
                @(negedge clk);
                if (cpu_read) begin ok = 1; gapn = n; end
            end
            check("bp_next_issue_delay", gapn, GAP + 3);
        end
        wait_rsp(2, "bp_rsp_timeout");
        if (rsp_q.size() == 2) check("bp_rsp_data", {rsp_q[0].data, rsp_q[1].data}, 16'h3C3C);

        // Reset in the middle of a request with two queued
        repeat (3) @(posedge clk); #1;
        lat = 0;
        push(1'b0, 32'h300, 32'h0);
        push(1'b0, 32'h304, 32'h0);
        push(1'b0, 32'h308, 32'h0);
        @(negedge clk);
        check("mid_rst_req_high", cpu_read, 1);
        #2 rst = 1'b0;
        #1 check("mid_rst_req_drop", cpu_read, 0);
        clear_q();
        lat = 1;
        @(posedge clk); #3 rst = 1'b1;
        #1 check("post_rst_busy_ready", {busy, cmd_ready}, 2'b01);
        repeat (10) @(posedge clk); #1;
        check("post_rst_no_activity", {rsp_q.size(), iss_q.size()}, 64'd0);

`ifdef CACHE_REQ_TIMEOUT_EN
        // Cache never answers the first request; the second one completes
        clear_q();
        lat = 0; cpu_data_in = 8'h99;
        push(1'b0, 32'h400, 32'h0);
        push(1'b0, 32'h404, 32'h0);
        wait_rsp(1, "tmo_rsp_timeout");
        lat = 1;
        if (rsp_q.size() > 0) check("tmo_rsp0", {rsp_q[0].err, rsp_q[0].data}, {1'b1, 8'h00});
        if (len_q.size() > 0) check("tmo_req_len", len_q[0], TMO);
        wait_rsp(2, "tmo_rsp2_timeout");
        if (rsp_q.size() == 2) check("tmo_rsp1", {rsp_q[1].err, rsp_q[1].data}, {1'b0, 8'h99});
`endif

        check("never_both_lines", both_hi, 0);
        check("addr_stable_in_issue", unstable, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    // Global guard against a stuck run
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
